// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching CPU control path: instruction opcodes,
// ALU operation codes and the sequencer state encoding.
package cpu_pkg;

  // Instruction opcodes, taken from IR[15:12]
  localparam logic [3:0] OP_CLR  = 4'h0;
  localparam logic [3:0] OP_COM  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_CSL  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_STO  = 4'h5;
  localparam logic [3:0] OP_LOAD = 4'h6;
  localparam logic [3:0] OP_JMI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes; chosen so that opcodes 0..7 map onto them directly
  localparam logic [3:0] ALU_ZERO  = 4'h0;
  localparam logic [3:0] ALU_NOT   = 4'h1;
  localparam logic [3:0] ALU_SHR   = 4'h2;
  localparam logic [3:0] ALU_ROL   = 4'h3;
  localparam logic [3:0] ALU_ADD   = 4'h4;
  localparam logic [3:0] ALU_PASSA = 4'h5;
  localparam logic [3:0] ALU_PASSB = 4'h6;
  localparam logic [3:0] ALU_TSTN  = 4'h7;

  // Sequencer states
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    WRITE   = 3'd4,
    HALT    = 3'd5
  } state_t;

  // Codes 9..E have no instruction assigned to them
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator CPU.
// Owns PC, IR, ACC and the operand register OPR, talks to memory over a
// req/ack port and drives the external ALU.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes set a sticky
// illegalOp flag and halt; without it they execute as a NOP.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              runEn,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWData,
  input  logic [15:0]       memRData,
  input  logic              memAck,
  output logic [3:0]        aluCode,
  output logic [15:0]       aluInA,
  output logic [15:0]       aluInB,
  input  logic [15:0]       aluData,
  input  logic              ifBan,
  output logic [ADDR_W-1:0] pcOut,
  output logic [15:0]       accOut,
  output logic              halted,
  output logic              illegalOp
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       opr_q, opr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              fetch_pend_q, fetch_pend_d;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  logic              mem_req_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [3:0]        alu_code_c;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              unused_ir;

  assign opcode    = ir_q[15:12];
  assign operand   = ir_q[ADDR_W-1:0];
  assign unused_ir = ^ir_q;

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      acc_q        <= '0;
      opr_q        <= '0;
      wdata_q      <= '0;
      fetch_pend_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      acc_q        <= acc_d;
      opr_q        <= opr_d;
      wdata_q      <= wdata_d;
      fetch_pend_q <= fetch_pend_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= illegal_d;
`endif
    end
  end

  // Next-state, register updates and memory/ALU controls per state
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    acc_d        = acc_q;
    opr_d        = opr_q;
    wdata_d      = wdata_q;
    fetch_pend_d = fetch_pend_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d    = illegal_q;
`endif
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    alu_code_c   = ALU_ZERO;

    case (state_q)
      FETCH: begin
        // runEn only gates issuing a fetch; once issued it is held to ack
        if (runEn || fetch_pend_q) begin
          mem_req_c  = 1'b1;
          mem_addr_c = pc_q;
          if (memAck) begin
            ir_d         = memRData;
            pc_d         = pc_q + PC_ONE;
            fetch_pend_d = 1'b0;
            state_d      = DECODE;
          end else begin
            fetch_pend_d = 1'b1;
          end
        end
      end

      DECODE: begin
        if (opcode == OP_ADD || opcode == OP_LOAD) begin
          state_d = OPERAND;
        end else if (opcode == OP_JMP) begin
          pc_d    = operand;
          state_d = FETCH;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else if (is_illegal(opcode)) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = HALT;
`else
          state_d   = FETCH;
`endif
        end else begin
          state_d = EXEC;
        end
      end

      OPERAND: begin
        mem_req_c  = 1'b1;
        mem_addr_c = operand;
        if (memAck) begin
          opr_d   = memRData;
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_code_c = opcode;
        state_d    = FETCH;
        if (opcode == OP_STO) begin
          wdata_d = aluData;
          state_d = WRITE;
        end else if (opcode == OP_JMI) begin
          if (ifBan) begin
            pc_d = operand;
          end
        end else begin
          acc_d = aluData;
        end
      end

      WRITE: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = operand;
        if (memAck) begin
          state_d = FETCH;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign memReq   = mem_req_c & ~rst;
  assign memWe    = mem_we_c & ~rst;
  assign memAddr  = mem_addr_c;
  assign memWData = wdata_q;
  assign aluCode  = alu_code_c;
  assign aluInA   = acc_q;
  assign aluInB   = opr_q;
  assign pcOut    = pc_q;
  assign accOut   = acc_q;
  assign halted   = (state_q == HALT);
`ifdef ILLEGAL_TRAP_EN
  assign illegalOp = illegal_q;
`else
  assign illegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a wait-state memory model and
// a behavioural ALU. Honours ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        runEn;
  logic        memReq;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memAck;
  logic [3:0]  aluCode;
  logic [15:0] aluInA;
  logic [15:0] aluInB;
  logic [15:0] aluData;
  logic        ifBan;
  logic [7:0]  pcOut;
  logic [15:0] accOut;
  logic        halted;
  logic        illegalOp;

  logic [15:0] mem [0:255];
  int          waitCycles;
  int          waitCnt;
  int          stableErr;
  int          wrCount;
  logic [7:0]  lastWrAddr;
  logic [15:0] lastWrData;
  logic [7:0]  capAddr;
  logic        capWe;

  int checks;
  int errors;
  int cycles;

  alu_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .runEn(runEn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .memRData(memRData), .memAck(memAck),
    .aluCode(aluCode), .aluInA(aluInA), .aluInB(aluInB),
    .aluData(aluData), .ifBan(ifBan),
    .pcOut(pcOut), .accOut(accOut), .halted(halted), .illegalOp(illegalOp)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU: combinational result and sign flag of the result
  always_comb begin
    case (aluCode)
      4'h0:    aluData = 16'h0000;
      4'h1:    aluData = ~aluInA;
      4'h2:    aluData = aluInA >> 1;
      4'h3:    aluData = {aluInA[14:0], aluInA[15]};
      4'h4:    aluData = aluInA + aluInB;
      4'h5:    aluData = aluInA;
      4'h6:    aluData = aluInB;
      4'h7:    aluData = aluInA;
      default: aluData = 16'h0000;
    endcase
    ifBan = aluData[15];
  end

  // Memory model: acks after waitCycles, checks request stability while waiting
  always @(negedge clk) begin
    if (rst || !memReq) begin
      memAck  = 1'b0;
      waitCnt = 0;
    end else begin
      if (waitCnt == 0) begin
        capAddr = memAddr;
        capWe   = memWe;
      end else if (memAddr !== capAddr || memWe !== capWe) begin
        stableErr++;
      end
      if (waitCnt >= waitCycles) begin
        memAck   = 1'b1;
        memRData = mem[memAddr];
        if (memWe) begin
          wrCount++;
          lastWrAddr = memAddr;
          lastWrData = memWData;
        end
        waitCnt = 0;
      end else begin
        memAck = 1'b0;
        waitCnt++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    wrCount = 0;
  endtask

  // Reset the DUT with the given memory latency, then enable it
  task automatic applyStimulus(input int waits);
    waitCycles = waits;
    rst   = 1'b1;
    runEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    runEn = 1'b1;
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic runUntilHalt(input int maxCycles, output int n);
    n = 0;
    while (halted !== 1'b1 && n < maxCycles) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    stableErr  = 0;
    waitCycles = 0;
    waitCnt    = 0;
    memAck     = 1'b0;
    memRData   = 16'h0000;
    rst        = 1'b1;
    runEn      = 1'b1;
    clearMem();

    // Reset state, with runEn already high
    #2;
    checkOutput("rst_memReq", memReq, 1'b0);
    checkOutput("rst_memWe", memWe, 1'b0);
    checkOutput("rst_pc", pcOut, 8'h00);
    checkOutput("rst_acc", accOut, 16'h0000);
    checkOutput("rst_wdata", memWData, 16'h0000);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_illegal", illegalOp, 1'b0);
    checkOutput("rst_aluCode", aluCode, 4'h0);

    // Idle in FETCH while runEn is low
    @(posedge clk); #1;
    runEn = 1'b0;
    rst   = 1'b0;
    runCycles(3);
    checkOutput("idle_memReq", memReq, 1'b0);
    checkOutput("idle_pc", pcOut, 8'h00);

    $display("[TB] LOAD/ADD/HALT zero-wait");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h4011;
    mem[8'h02] = 16'hF000;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h0FFF;
    applyStimulus(0);
    runUntilHalt(200, cycles);
    checkOutput("add_cycles", cycles, 10);
    checkOutput("add_acc", accOut, 16'h2233);
    checkOutput("add_pc", pcOut, 8'h03);
    checkOutput("add_halted", halted, 1'b1);
    checkOutput("add_haltReq", memReq, 1'b0);

    $display("[TB] LOAD/ADD/HALT three wait states");
    stableErr = 0;
    applyStimulus(3);
    runUntilHalt(200, cycles);
    checkOutput("wait_cycles", cycles, 25);
    checkOutput("wait_acc", accOut, 16'h2233);
    checkOutput("wait_stable", stableErr, 0);

    $display("[TB] JMI taken");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h7020;
    mem[8'h02] = 16'hF000;
    mem[8'h20] = 16'hF000;
    mem[8'h10] = 16'h8000;
    applyStimulus(0);
    runUntilHalt(200, cycles);
    checkOutput("jmiT_cycles", cycles, 9);
    checkOutput("jmiT_pc", pcOut, 8'h21);

    $display("[TB] JMI not taken");
    mem[8'h10] = 16'h7FFF;
    applyStimulus(0);
    runUntilHalt(200, cycles);
    checkOutput("jmiN_pc", pcOut, 8'h03);
    checkOutput("jmiN_acc", accOut, 16'h7FFF);

    $display("[TB] STO");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h5030;
    mem[8'h02] = 16'hF000;
    mem[8'h10] = 16'hBEEF;
    applyStimulus(0);
    runUntilHalt(200, cycles);
    checkOutput("sto_cycles", cycles, 10);
    checkOutput("sto_wrCount", wrCount, 1);
    checkOutput("sto_wrAddr", lastWrAddr, 8'h30);
    checkOutput("sto_wrData", lastWrData, 16'hBEEF);
    checkOutput("sto_acc", accOut, 16'hBEEF);
    checkOutput("sto_pc", pcOut, 8'h03);

    $display("[TB] COM/CSL/SHR chain");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h1000;
    mem[8'h02] = 16'h3000;
    mem[8'h03] = 16'h2000;
    mem[8'h04] = 16'hF000;
    mem[8'h10] = 16'h1234;
    applyStimulus(0);
    runUntilHalt(200, cycles);
    checkOutput("alu_cycles", cycles, 15);
    checkOutput("alu_acc", accOut, 16'h6DCB);
    checkOutput("alu_pc", pcOut, 8'h05);

    $display("[TB] PC wrap at 0xFF");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h80FF;
    mem[8'hFF] = 16'h0000;
    mem[8'h10] = 16'h5555;
    applyStimulus(0);
    runCycles(4);
    checkOutput("wrap_accLoad", accOut, 16'h5555);
    runCycles(2);
    checkOutput("wrap_pcJmp", pcOut, 8'hFF);
    runCycles(1);
    checkOutput("wrap_pcWrap", pcOut, 8'h00);
    runCycles(2);
    checkOutput("wrap_accClr", accOut, 16'h0000);

    $display("[TB] reset during OPERAND wait");
    clearMem();
    mem[8'h00] = 16'h6010;
    mem[8'h01] = 16'h6011;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h4321;
    applyStimulus(3);
    runCycles(17);
    checkOutput("mid_memReq", memReq, 1'b1);
    checkOutput("mid_addr", memAddr, 8'h11);
    checkOutput("mid_acc", accOut, 16'h1234);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst_memReq", memReq, 1'b0);
    checkOutput("midRst_pc", pcOut, 8'h00);
    checkOutput("midRst_acc", accOut, 16'h0000);

    $display("[TB] illegal opcode 0x9");
    clearMem();
    mem[8'h00] = 16'h9000;
    mem[8'h01] = 16'hF000;
    applyStimulus(0);
    runUntilHalt(200, cycles);
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill_cycles", cycles, 2);
    checkOutput("ill_pc", pcOut, 8'h01);
    checkOutput("ill_flag", illegalOp, 1'b1);
`else
    checkOutput("ill_cycles", cycles, 4);
    checkOutput("ill_pc", pcOut, 8'h02);
    checkOutput("ill_flag", illegalOp, 1'b0);
`endif
    checkOutput("ill_halted", halted, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
